decode_stage: RTL and testbench
===============================

# decode_stage

Registered RV32 instruction-decode stage sitting directly downstream of the fetch stage. It accepts one 32-bit instruction and its PC per handshake and splits it into register indices, a sign-extended immediate, a format code and an operation class. Results are held in a single pipeline register under valid/ready backpressure. It also tracks the fetch stage's end-of-program indication and raises `decode_done` once the last instruction has left the stage.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset
- `in_valid`  in  1  fetch presents a valid `in_instr`/`in_pc`
- `in_ready`  out  1  stage can accept this cycle
- `in_instr`  in  32  instruction word from fetch
- `in_pc`  in  32  byte address of `in_instr`
- `fetch_complete`  in  1  fetch has no more instructions; level, sticky
- `flush`  in  1  discard the held instruction
- `out_valid`  out  1  decoded fields valid
- `out_ready`  in  1  downstream consumes this cycle
- `out_pc`, `out_instr`  out  32 each  registered copies of the inputs
- `rd`, `rs1`, `rs2`  out  5 each  `instr[11:7]`, `[19:15]`, `[24:20]`
- `funct3`  out  3  `instr[14:12]`
- `funct7_5`  out  1  `instr[30]`
- `imm`  out  32  sign-extended immediate
- `fmt`  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5
- `op_class`  out  4  ALU=0, ALUI=1, LOAD=2, STORE=3, BRANCH=4, JAL=5, JALR=6, LUI=7, AUIPC=8, MULDIV=9, SYSTEM=10, ILLEGAL=15
- `uses_rs1`, `uses_rs2`, `writes_rd`  out  1 each  operand/destination usage
- `illegal`  out  1  instruction not decodable
- `decode_done`  out  1  all instructions drained

## Operation
- **Acceptance**
  - `in_ready = (state==RUN) && (!out_valid || out_ready)`.
  - Accept when `in_valid && in_ready`.
  - Fields are decoded combinationally from `in_instr` and registered on accept.
- **Opcode map** (`instr[6:0]`)
  - 0110011 → ALU (R).
  - 0010011 → ALUI (I).
  - 0000011 → LOAD (I).
  - 0100011 → STORE (S).
  - 1100011 → BRANCH (B).
  - 1101111 → JAL (J).
  - 1100111 → JALR (I).
  - 0110111 → LUI (U).
  - 0010111 → AUIPC (U).
  - 1110011 → SYSTEM (I).
  - Any other opcode, or `instr[1:0]!=2'b11`, gives `op_class=15` and `illegal=1`. This includes 0x00000000.
- **Immediates**
  - I: `instr[31:20]`, sign-extended.
  - S: `{instr[31:25],instr[11:7]}`, sign-extended.
  - B: `{instr[31],instr[7],instr[30:25],instr[11:8],1'b0}`, sign-extended.
  - U: `{instr[31:12],12'b0}`.
  - J: `{instr[31],instr[19:12],instr[20],instr[30:21],1'b0}`, sign-extended.
  - R and ILLEGAL: 0.
- **Usage flags**
  - `uses_rs1`: R, I, S, B.
  - `uses_rs2`: R, S, B.
  - `writes_rd`: R, I, U, J with `rd!=0`.
  - All three are 0 for ILLEGAL.
- **FSM** (`state`: RUN, DRAIN, DONE)
  - RUN → DRAIN when `fetch_complete && !(in_valid && in_ready)`. If an instruction is accepted in the same cycle, the transition waits one cycle.
  - DRAIN: `in_ready=0`. → DONE when `!out_valid`, or when `out_valid && out_ready`.
  - DONE: `decode_done=1`. Held until reset; `flush` is ignored.
- **flush**
  - Clears `out_valid` next cycle and blocks acceptance in the same cycle (`in_ready` forced 0).
  - Flush has priority over accept.
  - Does not change the FSM state, except that DRAIN then completes.

## Timing
- Reset (`reset==0` at a clock edge):
  - All outputs 0; `state=RUN`.
  - `in_ready` reads 1 in the cycle after reset deasserts.
- Reset applied mid-operation discards the held instruction with no output.
- Latency: accept at edge N gives `out_valid=1` with fields valid after edge N. One instruction per cycle when `out_ready` stays high.
- Backpressure: while `out_valid && !out_ready`, every output is stable and `in_ready=0`.
- Pop and push in the same cycle: the register is replaced. `out_valid` stays 1 with no bubble.
- `decode_done` rises one edge after the final pop (or one edge after entering DRAIN with the register empty).

## Configuration
- `DECODE_RV32M_EN`:
  - **Defined:** opcode 0110011 with `instr[31:25]==7'b0000001` decodes as `op_class=MULDIV`, `fmt=R`, using rs1, rs2 and rd.
  - **Undefined:** the same encoding gives `op_class=ILLEGAL` and `illegal=1`, with all usage flags 0.
  - All other decode is identical in both builds.

## Test plan
- `addi x1,x0,5` (0x00500093), `in_pc=0x10`, `out_ready=1`:
  - Next cycle: `out_valid=1`, `rd=1`, `rs1=0`, `imm=5`, `fmt=1`, `op_class=1`, `writes_rd=1`, `out_pc=0x10`.
- `sw x2,8(x1)` (0x0020A423): `imm=8`, `rs1=1`, `rs2=2`, `fmt=2`, `op_class=3`, `writes_rd=0`.
- `beq x0,x0,-4` (0xFE000EE3): `imm=0xFFFFFFFC`, `fmt=3`, `op_class=4`.
- 0x022081B3 (`mul x3,x1,x2`):
  - With `DECODE_RV32M_EN`: `op_class=9`, `rd=3`.
  - Without it: `op_class=15`, `illegal=1`.
  - 0x00000000 gives `illegal=1` in both builds.
- Backpressure: accept 0x00500093, then hold `out_ready=0` for 3 cycles with `in_valid=1`.
  - During the hold: outputs stable, `in_ready=0`.
  - On release: the next instruction is accepted in the pop cycle with no bubble.
- Drain: after the last accept, raise `fetch_complete` with `out_ready=0` for 2 cycles, then `out_ready=1`.
  - `decode_done=1` one edge after the pop and held.
  - `reset=0` clears it and returns `state` to RUN.

Source files
------------

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and downstream-side handshake/bus signals of decode_stage
// slave  : used by decode_stage (receives in_* / fetch_complete / flush / out_ready, drives the rest)
// master : used by the environment driving the stage (fetch + downstream consumer)
interface decode_stage_if;
  logic        in_valid, in_ready, fetch_complete, flush;
  logic [31:0] in_instr, in_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr, imm;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, fmt;
  logic        funct7_5;
  logic [3:0]  op_class;
  logic        uses_rs1, uses_rs2, writes_rd, illegal, decode_done;
  modport slave (
    input  in_valid, in_instr, in_pc, fetch_complete, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, rd, rs1, rs2, funct3, funct7_5,
           imm, fmt, op_class, uses_rs1, uses_rs2, writes_rd, illegal, decode_done
  );
  modport master (
    output in_valid, in_instr, in_pc, fetch_complete, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, rd, rs1, rs2, funct3, funct7_5,
           imm, fmt, op_class, uses_rs1, uses_rs2, writes_rd, illegal, decode_done
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32 decode stage with valid/ready backpressure and end-of-program drain tracking
// Ports: clk (rising edge), reset (synchronous, active-low),
//        bus (decode_stage_if.slave): fetch handshake in_valid/in_ready/in_instr/in_pc, fetch_complete, flush,
//        downstream handshake out_valid/out_ready, decoded fields, decode_done.
// Build option: DECODE_RV32M_EN makes the M-extension encoding (opcode 0110011, funct7 0000001) decode as MULDIV.
module decode_stage (
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;
  localparam logic [3:0] OP_ALU = 4'd0, OP_ALUI = 4'd1, OP_LOAD = 4'd2, OP_STORE = 4'd3, OP_BRANCH = 4'd4,
                         OP_JAL = 4'd5, OP_JALR = 4'd6, OP_LUI = 4'd7, OP_AUIPC = 4'd8, OP_SYSTEM = 4'd10,
                         OP_ILL = 4'd15;
`ifdef DECODE_RV32M_EN
  localparam logic [3:0] OP_M = 4'd9;
`else
  localparam logic [3:0] OP_M = OP_ILL;
`endif
  state_t      r_state, w_state_nxt;
  logic        w_in_ready, w_accept;
  logic [31:0] w_instr, w_imm;
  logic [3:0]  w_op;
  logic [2:0]  w_fmt;
  logic        w_ill, w_u1, w_u2, w_wr;
  logic        r_valid, r_u1, r_u2, r_wr, r_ill;
  logic [31:0] r_pc, r_instr, r_imm;
  logic [3:0]  r_op;
  logic [2:0]  r_fmt;
  assign w_instr = bus.in_instr;
  // Illegal encodings keep fmt=R so the immediate falls out as 0 without extra gating.
  always_comb begin
    w_op  = OP_ILL;
    w_fmt = F_R;
    case (w_instr[6:0])
      7'b0110011: w_op = (w_instr[31:25] == 7'b0000001) ? OP_M : OP_ALU;
      7'b0010011: begin w_op = OP_ALUI;   w_fmt = F_I; end
      7'b0000011: begin w_op = OP_LOAD;   w_fmt = F_I; end
      7'b0100011: begin w_op = OP_STORE;  w_fmt = F_S; end
      7'b1100011: begin w_op = OP_BRANCH; w_fmt = F_B; end
      7'b1101111: begin w_op = OP_JAL;    w_fmt = F_J; end
      7'b1100111: begin w_op = OP_JALR;   w_fmt = F_I; end
      7'b0110111: begin w_op = OP_LUI;    w_fmt = F_U; end
      7'b0010111: begin w_op = OP_AUIPC;  w_fmt = F_U; end
      7'b1110011: begin w_op = OP_SYSTEM; w_fmt = F_I; end
      default:    w_op = OP_ILL;
    endcase
    w_ill = (w_op == OP_ILL);
    w_imm = (w_fmt == F_I) ? {{20{w_instr[31]}}, w_instr[31:20]} :
            (w_fmt == F_S) ? {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]} :
            (w_fmt == F_B) ? {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0} :
            (w_fmt == F_U) ? {w_instr[31:12], 12'b0} :
            (w_fmt == F_J) ? {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0} :
            32'd0;
    w_u1 = !w_ill && (w_fmt <= F_B);
    w_u2 = !w_ill && (w_fmt == F_R || w_fmt == F_S || w_fmt == F_B);
    w_wr = !w_ill && (w_fmt != F_S) && (w_fmt != F_B) && (w_instr[11:7] != 5'd0);
  end
  // Flush and reset both block acceptance in the cycle they are asserted.
  always_comb begin
    w_in_ready  = reset && (r_state == RUN) && (!r_valid || bus.out_ready) && !bus.flush;
    w_accept    = bus.in_valid && w_in_ready;
    w_state_nxt = (r_state == RUN && bus.fetch_complete && !w_accept) ? DRAIN :
                  (r_state == DRAIN && (!r_valid || bus.out_ready)) ? DONE : r_state;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
      r_imm   <= '0;
      r_op    <= '0;
      r_fmt   <= '0;
      r_u1    <= 1'b0;
      r_u2    <= 1'b0;
      r_wr    <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_pc    <= bus.in_pc;
        r_instr <= w_instr;
        r_imm   <= w_imm;
        r_op    <= w_op;
        r_fmt   <= w_fmt;
        r_u1    <= w_u1;
        r_u2    <= w_u2;
        r_wr    <= w_wr;
        r_ill   <= w_ill;
      end else if (bus.out_ready || bus.flush) begin
        r_valid <= 1'b0;
      end
    end
  end
  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_valid;
  assign bus.out_pc      = r_pc;
  assign bus.out_instr   = r_instr;
  assign bus.rd          = r_instr[11:7];
  assign bus.rs1         = r_instr[19:15];
  assign bus.rs2         = r_instr[24:20];
  assign bus.funct3      = r_instr[14:12];
  assign bus.funct7_5    = r_instr[30];
  assign bus.imm         = r_imm;
  assign bus.fmt         = r_fmt;
  assign bus.op_class    = r_op;
  assign bus.uses_rs1    = r_u1;
  assign bus.uses_rs2    = r_u2;
  assign bus.writes_rd   = r_wr;
  assign bus.illegal     = r_ill;
  assign bus.decode_done = (r_state == DONE);
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized and directed checks of decode_stage against a behavioural model
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  decode_stage_if bus();
  decode_stage dut (.clk(clk), .reset(reset), .bus(bus));
`ifdef DECODE_RV32M_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif
  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        u1, u2, wr, ill;
  } dec_t;
  int n_cmp = 0;
  int n_bad = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = '0, m_pc = '0;
  int          m_phase = 0;
  logic [2:0]  fmt_of [16] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd4, 3'd4, 3'd0, 3'd1,
                               3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
  logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h73};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic dec_t ref_dec(input logic [31:0] x);
    dec_t d;
    int v;
    case (x[6:0])
      7'h33:   d.op = (x[31:25] == 7'h01) ? (MEXT ? 4'd9 : 4'd15) : 4'd0;
      7'h13:   d.op = 4'd1;
      7'h03:   d.op = 4'd2;
      7'h23:   d.op = 4'd3;
      7'h63:   d.op = 4'd4;
      7'h6f:   d.op = 4'd5;
      7'h67:   d.op = 4'd6;
      7'h37:   d.op = 4'd7;
      7'h17:   d.op = 4'd8;
      7'h73:   d.op = 4'd10;
      default: d.op = 4'd15;
    endcase
    d.fmt = fmt_of[d.op];
    d.ill = (d.op == 4'd15);
    case (d.fmt)
      3'd1:    v = int'(x[31:20]) - (x[31] ? 4096 : 0);
      3'd2:    v = int'({x[31:25], x[11:7]}) - (x[31] ? 4096 : 0);
      3'd3:    v = 2 * int'({x[31], x[7], x[30:25], x[11:8]}) - (x[31] ? 8192 : 0);
      3'd4:    v = int'(x & 32'hFFFFF000);
      3'd5:    v = 2 * int'({x[31], x[19:12], x[20], x[30:21]}) - (x[31] ? 2097152 : 0);
      default: v = 0;
    endcase
    d.imm = 32'(v);
    d.u1  = !d.ill && (d.fmt inside {3'd0, 3'd1, 3'd2, 3'd3});
    d.u2  = !d.ill && (d.fmt inside {3'd0, 3'd2, 3'd3});
    d.wr  = !d.ill && (d.fmt inside {3'd0, 3'd1, 3'd4, 3'd5}) && (x[11:7] != 5'd0);
    return d;
  endfunction
  function automatic logic m_rdy();
    return reset && (m_phase == 0) && (!m_valid || bus.out_ready) && !bus.flush;
  endfunction
  task automatic compare();
    dec_t d;
    d = ref_dec(m_instr);
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy()));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("decode_done", 32'(bus.decode_done), 32'(m_phase == 2));
    if (m_valid) begin
      chk("out_pc", bus.out_pc, m_pc);
      chk("out_instr", bus.out_instr, m_instr);
      chk("rd", 32'(bus.rd), 32'(m_instr[11:7]));
      chk("rs1", 32'(bus.rs1), 32'(m_instr[19:15]));
      chk("rs2", 32'(bus.rs2), 32'(m_instr[24:20]));
      chk("funct3", 32'(bus.funct3), 32'(m_instr[14:12]));
      chk("funct7_5", 32'(bus.funct7_5), 32'(m_instr[30]));
      chk("imm", bus.imm, d.imm);
      chk("fmt", 32'(bus.fmt), 32'(d.fmt));
      chk("op_class", 32'(bus.op_class), 32'(d.op));
      chk("uses_rs1", 32'(bus.uses_rs1), 32'(d.u1));
      chk("uses_rs2", 32'(bus.uses_rs2), 32'(d.u2));
      chk("writes_rd", 32'(bus.writes_rd), 32'(d.wr));
      chk("illegal", 32'(bus.illegal), 32'(d.ill));
    end
  endtask
  task automatic update();
    logic acc;
    acc = bus.in_valid && m_rdy();
    if (!reset) begin
      m_valid = 1'b0;
      m_phase = 0;
      m_instr = '0;
      m_pc    = '0;
    end else begin
      if (m_phase == 0 && bus.fetch_complete && !acc) m_phase = 1;
      else if (m_phase == 1 && (!m_valid || bus.out_ready)) m_phase = 2;
      if (acc) begin
        m_valid = 1'b1;
        m_instr = bus.in_instr;
        m_pc    = bus.in_pc;
      end else if (bus.out_ready || bus.flush) m_valid = 1'b0;
    end
  endtask
  task automatic step();
    #1 compare();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask
  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid  = 1'b1;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = 1'b1;
    step();
  endtask
  function automatic logic [31:0] rnd_instr();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      0:       return x;
      1:       return {7'b0000001, x[24:7], 7'b0110011};
      2:       return 32'd0;
      default: return {x[31:7], ops[$urandom_range(0, 9)]};
    endcase
  endfunction
  task automatic rnd_inputs(input logic fc);
    bus.in_valid       = $urandom_range(0, 3) != 0;
    bus.out_ready      = $urandom_range(0, 3) != 0;
    bus.flush          = $urandom_range(0, 15) == 0;
    bus.in_instr       = rnd_instr();
    bus.in_pc          = $urandom & 32'hFFFFFFFC;
    bus.fetch_complete = fc;
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.fetch_complete = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_imm", bus.imm, 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_op_class", 32'(bus.op_class), 32'd0);
    chk("rst_decode_done", 32'(bus.decode_done), 32'd0);
    reset = 1'b1;
    #1 chk("ready_after_reset", 32'(bus.in_ready), 32'd1);
    push(32'h00500093, 32'h10);
    chk("addi_valid", 32'(bus.out_valid), 32'd1);
    chk("addi_rd", 32'(bus.rd), 32'd1);
    chk("addi_rs1", 32'(bus.rs1), 32'd0);
    chk("addi_imm", bus.imm, 32'd5);
    chk("addi_fmt", 32'(bus.fmt), 32'd1);
    chk("addi_op", 32'(bus.op_class), 32'd1);
    chk("addi_wr", 32'(bus.writes_rd), 32'd1);
    chk("addi_pc", bus.out_pc, 32'h10);
    push(32'h0020A423, 32'h14);
    chk("sw_imm", bus.imm, 32'd8);
    chk("sw_rs1", 32'(bus.rs1), 32'd1);
    chk("sw_rs2", 32'(bus.rs2), 32'd2);
    chk("sw_fmt", 32'(bus.fmt), 32'd2);
    chk("sw_op", 32'(bus.op_class), 32'd3);
    chk("sw_wr", 32'(bus.writes_rd), 32'd0);
    push(32'hFE000EE3, 32'h18);
    chk("beq_imm", bus.imm, 32'hFFFFFFFC);
    chk("beq_fmt", 32'(bus.fmt), 32'd3);
    chk("beq_op", 32'(bus.op_class), 32'd4);
    push(32'h022081B3, 32'h1C);
    chk("mul_op", 32'(bus.op_class), MEXT ? 32'd9 : 32'd15);
    chk("mul_ill", 32'(bus.illegal), MEXT ? 32'd0 : 32'd1);
    chk("mul_rd", 32'(bus.rd), 32'd3);
    push(32'h00000000, 32'h20);
    chk("zero_ill", 32'(bus.illegal), 32'd1);
    chk("zero_op", 32'(bus.op_class), 32'd15);
    push(32'h00500093, 32'h100);
    bus.out_ready = 1'b0;
    bus.in_instr  = 32'h0020A423;
    bus.in_pc     = 32'h104;
    repeat (3) begin
      step();
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_pc", bus.out_pc, 32'h100);
      chk("bp_instr", bus.out_instr, 32'h00500093);
      chk("bp_imm", bus.imm, 32'd5);
    end
    bus.out_ready = 1'b1;
    #1 chk("pop_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("nobubble_valid", 32'(bus.out_valid), 32'd1);
    chk("nobubble_pc", bus.out_pc, 32'h104);
    repeat (1500) begin
      rnd_inputs(1'b0);
      reset = $urandom_range(0, 199) != 0;
      step();
    end
    reset = 1'b1;
    bus.flush = 1'b0;
    push(32'h00500093, 32'h200);
    bus.in_valid       = 1'b0;
    bus.fetch_complete = 1'b1;
    bus.out_ready      = 1'b0;
    repeat (2) begin
      step();
      chk("drain_hold_done", 32'(bus.decode_done), 32'd0);
      chk("drain_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    step();
    chk("drain_done", 32'(bus.decode_done), 32'd1);
    chk("drain_empty", 32'(bus.out_valid), 32'd0);
    repeat (5) begin
      rnd_inputs(1'b1);
      step();
      chk("done_held", 32'(bus.decode_done), 32'd1);
    end
    reset = 1'b0;
    step();
    chk("done_cleared", 32'(bus.decode_done), 32'd0);
    reset = 1'b1;
    bus.fetch_complete = 1'b0;
    bus.flush = 1'b0;
    #1 chk("rerun_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (8) begin
      reset = 1'b0;
      step();
      reset = 1'b1;
      repeat ($urandom_range(5, 40)) begin
        rnd_inputs(1'b0);
        step();
      end
      repeat (20) begin
        rnd_inputs(1'b1);
        step();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
